// File: rtl/barcode_pkg.sv
// Shared types and defaults for the barcode reader.
package barcode_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_FALL,
    SAMPLE
  } bc_state_t;

  localparam int TIMER_W_DEF    = 22;
  localparam int MIN_PERIOD_DEF = 16;

  // Station IDs occupy the low six bits; anything else on the track is not ours.
  localparam logic [1:0] ID_PREFIX = 2'b00;

endpackage

// File: rtl/bc_sync.sv
// Two-flop synchronizer for the raw barcode line plus an edge-detect flop.
module bc_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic bc,
  output logic bc_s,
  output logic bc_fall,
  output logic bc_rise
);

  // [0] metastable capture, [1] synchronized level, [2] previous level
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], bc};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign bc_s    = sync_q[1];
  assign bc_fall = sync_q[2] & ~sync_q[1];
  assign bc_rise = ~sync_q[2] & sync_q[1];

endmodule

// File: rtl/barcode_rdr.sv
// Self-clocked barcode decoder: measures the start-bit period, samples 8 data
// bits MSB first and presents accepted station IDs with a sticky valid flag.
module barcode_rdr
  import barcode_pkg::*;
#(
  parameter int TIMER_W    = TIMER_W_DEF,
  parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       BC,
  input  logic       clr_ID_vld,
  output logic [7:0] ID,
  output logic       ID_vld
);

  localparam logic [TIMER_W-1:0] TIMER_MAX = '1;
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] MIN_P     = TIMER_W'(MIN_PERIOD);

  logic bc_s;
  logic bc_fall;
  logic bc_rise;

  bc_state_t          state_q,   state_d;
  logic [TIMER_W-1:0] timer_q,   timer_d;
  logic [TIMER_W-1:0] period_q,  period_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q,   shift_d;
  logic [7:0]         id_q,      id_d;
  logic               id_vld_q,  id_vld_d;

  logic [TIMER_W-1:0] timer_inc;
  logic [7:0]         shift_nxt;

  bc_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .bc      (BC),
    .bc_s    (bc_s),
    .bc_fall (bc_fall),
    .bc_rise (bc_rise)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    period_d  = period_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    id_d      = id_q;
    id_vld_d  = id_vld_q;
    timer_inc = timer_q + TIMER_ONE;
    shift_nxt = {shift_q[6:0], bc_s};

    // A frame completing on this edge overrides the acknowledge below.
    if (clr_ID_vld) begin
      id_vld_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bc_fall) begin
          timer_d = '0;
          state_d = START;
        end
      end

      START: begin
        if (timer_q == TIMER_MAX) begin
          state_d = IDLE;
        end else if (bc_rise) begin
          if (timer_q >= MIN_P) begin
            period_d  = timer_q;
            bit_cnt_d = 3'd0;
            timer_d   = timer_inc;
            state_d   = WAIT_FALL;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_inc;
        end
      end

      WAIT_FALL: begin
        if (timer_q == TIMER_MAX) begin
          state_d = IDLE;
        end else if (bc_fall) begin
          timer_d = '0;
          state_d = SAMPLE;
        end else begin
          timer_d = timer_inc;
        end
      end

      SAMPLE: begin
        if (timer_q == TIMER_MAX) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_inc;
          if (timer_q == period_q) begin
            shift_d   = shift_nxt;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = IDLE;
              if (shift_nxt[7:6] == ID_PREFIX) begin
                id_d     = shift_nxt;
                id_vld_d = 1'b1;
              end
            end else begin
              state_d = WAIT_FALL;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      period_q  <= '0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      id_q      <= 8'h00;
      id_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      period_q  <= period_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      id_q      <= id_d;
      id_vld_q  <= id_vld_d;
    end
  end

  assign ID     = id_q;
  assign ID_vld = id_vld_q;

endmodule
